// File: rtl/q2_pkg.sv
// Shared widths and the stage-1 payload of the two-stage 32-bit subtractor.
package q2_pkg;
    localparam int DATA_W  = 32;
    localparam int SLICE_W = 16;

    typedef struct packed {
        logic [SLICE_W-1:0] lo_diff;
        logic               borrow;
        logic [SLICE_W-1:0] a_hi;
        logic [SLICE_W-1:0] b_hi;
    } s1_payload_t;
endpackage

// File: rtl/q2_16b_sub.sv
// Combinational 16-bit slice subtractor: diff = a - b - bin, bout is the slice borrow.
module q2_16b_sub
    import q2_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout
);
    logic [SLICE_W:0] wide_s;

    // One extra bit catches the borrow as the wrap of the 17-bit difference.
    always_comb begin
        wide_s = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bin};
        diff   = wide_s[SLICE_W-1:0];
        bout   = wide_s[SLICE_W];
    end
endmodule

// File: rtl/q2_32b_sub_pipe.sv
// Two-stage valid/ready 32-bit subtractor; low slice in stage 1, high slice in stage 2.
// Define Q2_SUB_OVF_EN to add the registered signed-overflow output ovf.
module q2_32b_sub_pipe
    import q2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout
`ifdef Q2_SUB_OVF_EN
    ,
    output logic              ovf
`endif
);
    logic          s1_valid_r;
    logic          s2_valid_r;
    s1_payload_t   s1_r;
    logic          s1_adv_s;
    logic          s2_adv_s;
    logic [SLICE_W-1:0] lo_diff_s;
    logic               lo_borrow_s;
    logic [SLICE_W-1:0] hi_diff_s;
    logic               hi_borrow_s;

    q2_16b_sub u_lo (
        .a    (a[SLICE_W-1:0]),
        .b    (b[SLICE_W-1:0]),
        .bin  (bin),
        .diff (lo_diff_s),
        .bout (lo_borrow_s)
    );

    q2_16b_sub u_hi (
        .a    (s1_r.a_hi),
        .b    (s1_r.b_hi),
        .bin  (s1_r.borrow),
        .diff (hi_diff_s),
        .bout (hi_borrow_s)
    );

    // Stage advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv_s = !s2_valid_r || out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
        in_ready = s1_adv_s;
    end

    // Valid flags are the only reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Payload registers load only on a transfer into their stage.
    always_ff @(posedge clk) begin
        if (in_valid && s1_adv_s) begin
            s1_r.lo_diff <= lo_diff_s;
            s1_r.borrow  <= lo_borrow_s;
            s1_r.a_hi    <= a[DATA_W-1:SLICE_W];
            s1_r.b_hi    <= b[DATA_W-1:SLICE_W];
        end
        if (s1_valid_r && s2_adv_s) begin
            diff <= {hi_diff_s, s1_r.lo_diff};
            bout <= hi_borrow_s;
`ifdef Q2_SUB_OVF_EN
            ovf  <= (s1_r.a_hi[SLICE_W-1] != s1_r.b_hi[SLICE_W-1]) &&
                    (hi_diff_s[SLICE_W-1] != s1_r.a_hi[SLICE_W-1]);
`endif
        end
    end

    assign out_valid = s2_valid_r;
endmodule

// File: tb/tb_q2_32b_sub_pipe.sv
// Self-checking bench for q2_32b_sub_pipe: directed vectors, random streams, reset flush.
module tb_q2_32b_sub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
`ifdef Q2_SUB_OVF_EN
    logic        ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [33:0] q[$];

    q2_32b_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef Q2_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain wide arithmetic.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
        logic [32:0] wide;
        logic [32:0] sub;
        logic        o;
        wide = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        sub  = {1'b0, mb} + {32'd0, mbin};
        o    = (ma[31] != mb[31]) && (wide[31] != ma[31]);
        return {o, ({1'b0, ma} < sub), wide[31:0]};
    endfunction

    task automatic directed(input string tag, input logic [31:0] da, input logic [31:0] db,
                            input logic dbin, input logic [31:0] ediff, input logic ebout,
                            input logic eovf);
        a = da; b = db; bin = dbin; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_diff"}, diff, ediff);
        chk({tag, "_bout"}, bout, ebout);
`ifdef Q2_SUB_OVF_EN
        chk({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf !== 1'b0 && eovf !== 1'b1) $display("note: %s overflow reference undefined", tag);
`endif
        @(posedge clk); @(negedge clk);
    endtask

    task automatic stream(input string tag, input int n, input bit toggle, input bit check_tp);
        int sent = 0;
        int rxed = 0;
        int cyc  = 0;
        bit have = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] ra, rb, prev_diff;
        logic rbin, prev_bout;
        logic [33:0] head;
        while (rxed < n && cyc < 400) begin
            if (!have && sent < n) begin
                ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            a = ra; b = rb; bin = rbin; in_valid = have;
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            chk({tag, "_in_ready"}, in_ready, !(q.size() == 2 && !out_ready));
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, out_valid, 1'b1);
                chk({tag, "_hold_diff"}, diff, prev_diff);
                chk({tag, "_hold_bout"}, bout, prev_bout);
            end
            if (out_valid) begin
                chk({tag, "_nonempty"}, (q.size() > 0), 1'b1);
                if (q.size() > 0) begin
                    head = q[0];
                    chk({tag, "_diff"}, diff, head[31:0]);
                    chk({tag, "_bout"}, bout, head[32]);
`ifdef Q2_SUB_OVF_EN
                    chk({tag, "_ovf"}, ovf, head[33]);
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        rxed++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_diff  = diff;
            prev_bout  = bout;
            if (in_valid && in_ready) begin
                q.push_back(model(ra, rb, rbin));
                sent++;
                have = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, rxed, n);
        if (check_tp) chk({tag, "_cycles"}, cyc, n + 2);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; bin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        directed("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        directed("wrap", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("xslice", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
        directed("sovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed("bigb", 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0);

        stream("burst", 8, 1'b0, 1'b1);
        stream("toggle", 10, 1'b1, 1'b0);

        // Fill both stages under backpressure, then reset.
        a = 32'h1234_5678; b = 32'h0000_0001; bin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            #1;
            chk("post_rst_stale", out_valid, 1'b0);
        end
        q.delete();

        stream("after_rst", 4, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
